uart_cmd_bridge: RTL and testbench

Host-side consumer of the UART byte interface. It takes bytes from the rx_flag/rx_ack handshake, parses a fixed-format read/write command protocol, and runs one transaction on a simple request/acknowledge memory bus. It returns one response byte through the tx_wr/tx_flag handshake. It sits between the UART wrapper and on-chip memory or registers as the board debug/load port.

---
 rtl/uart_cmd_bridge_if.sv | 24 ++
 rtl/uart_cmd_bridge.sv | 91 +++++++++
 tb/tb_uart_cmd_bridge.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_bridge_if.sv
// uart_cmd_bridge_if: UART byte handshake plus the request/acknowledge memory bus.
// master is the bridge side; slave is the UART wrapper / memory side.
interface uart_cmd_bridge_if #(parameter int ADDR_W = 16);
    logic [7:0]        rx_data;
    logic              rx_flag;
    logic              rx_ack;
    logic [7:0]        tx_data;
    logic              tx_flag;
    logic              tx_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_req;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    modport master (
        input  rx_data, rx_flag, tx_flag, mem_rdata, mem_ack,
        output rx_ack, tx_data, tx_wr, mem_addr, mem_wdata, mem_we, mem_req
    );
    modport slave (
        output rx_data, rx_flag, tx_flag, mem_rdata, mem_ack,
        input  rx_ack, tx_data, tx_wr, mem_addr, mem_wdata, mem_we, mem_req
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: parses 'W' AH AL D / 'R' AH AL commands from the UART, runs one
// memory bus transaction and answers with one byte ('K', read data or '?').
module uart_cmd_bridge #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 5000000
) (
    input logic clk,
    input logic reset,
    uart_cmd_bridge_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX_REQ, TX_WAIT} state_t;
    state_t            state_q;
    logic              is_wr_q, rx_ack_q, tx_wr_q, mem_req_q, mem_we_q;
    logic [7:0]        ah_q, tx_data_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [CW-1:0]     cnt_q;
    logic              take, done, tmo, in_cmd;
    logic [15:0]       addr_full;
    // rx_ack_q blocks the cycle right after an ack, when rx_flag is still settling low
    assign take      = (state_q inside {IDLE, ADDR_HI, ADDR_LO, DATA}) && bus.rx_flag && !rx_ack_q;
    assign in_cmd    = state_q inside {ADDR_HI, ADDR_LO, DATA};
    assign done      = mem_req_q && bus.mem_ack;
    assign tmo       = cnt_q == CW'(TIMEOUT - 1);
    assign addr_full = {ah_q, bus.rx_data};
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            rx_ack_q    <= 1'b0;
            tx_wr_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            ah_q        <= '0;
            tx_data_q   <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            rx_ack_q <= take;
            tx_wr_q  <= 1'b0;
            cnt_q    <= (take || !in_cmd) ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: if (take) begin
                    if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) begin
                        is_wr_q <= bus.rx_data == 8'h57;
                        state_q <= ADDR_HI;
                    end else begin
                        tx_data_q <= 8'h3F;
                        state_q   <= TX_REQ;
                    end
                end
                ADDR_HI: if (take) begin
                    ah_q    <= bus.rx_data;
                    state_q <= ADDR_LO;
                end else if (tmo) state_q <= IDLE;
                ADDR_LO: if (take) begin
                    mem_addr_q <= addr_full[ADDR_W-1:0];
                    state_q    <= is_wr_q ? DATA : BUS;
                end else if (tmo) state_q <= IDLE;
                DATA: if (take) begin
                    mem_wdata_q <= bus.rx_data;
                    state_q     <= BUS;
                end else if (tmo) state_q <= IDLE;
                BUS: if (done) begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    tx_data_q <= mem_we_q ? 8'h4B : bus.mem_rdata;
                    tx_wr_q   <= bus.tx_flag;
                    state_q   <= bus.tx_flag ? TX_WAIT : TX_REQ;
                end else begin
                    mem_req_q <= 1'b1;
                    mem_we_q  <= is_wr_q;
                end
                TX_REQ: if (bus.tx_flag) begin
                    tx_wr_q <= 1'b1;
                    state_q <= TX_WAIT;
                end
                TX_WAIT: if (!tx_wr_q && bus.tx_flag) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.rx_ack    = rx_ack_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_wr     = tx_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_req   = mem_req_q;
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: directed and random command streams against a byte-level protocol
// model, with a UART source, a transmitter and a RAM with configurable ack delay.
module tb_uart_cmd_bridge;
    localparam int AW = 16, TMO = 100;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    uart_cmd_bridge_if #(.ADDR_W(AW)) bus ();
    uart_cmd_bridge #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_assert = 0, n_fail = 0, cyc = 0;
    byte unsigned rxq[$];
    logic [AW+8:0] ops_exp[$], ops_act[$], cur_op;
    logic [7:0] resp_exp[$], resp_act[$];
    logic [7:0] ram [0:65535];
    logic [7:0] ref_mem [0:65535];
    int rx_gap = 0, n_rx_ack = 0, n_mem_req = 0, n_tx_wr = 0, tx_busy = 0;
    int ack_dly = 0, mem_cnt = 0, rxack_cyc = -100, want_txwr = -1;
    bit mem_hang = 0, tx_hold = 0, rand_dly = 0, prev_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rx_ack) begin
            n_rx_ack++;
            rxack_cyc = cyc;
            if (rxq.size() > 0) void'(rxq.pop_front());
            rx_gap = 1 + $urandom_range(0, 3);
        end else if (rx_gap > 0) begin
            bus.rx_flag = 1'b0;
            rx_gap--;
        end else begin
            bus.rx_flag = rxq.size() > 0;
            if (rxq.size() > 0) bus.rx_data = rxq[0];
        end
        if (cyc == want_txwr) chk("ack_to_txwr", bus.tx_wr, 1);
        if (bus.tx_wr) begin
            n_tx_wr++;
            resp_act.push_back(bus.tx_data);
            tx_busy = 2 + $urandom_range(0, 5);
        end else begin
            if (tx_busy > 0) tx_busy--;
            bus.tx_flag = !(tx_busy > 0 || tx_hold);
        end
        if (bus.mem_req && !prev_req) begin
            n_mem_req++;
            cur_op = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00};
            ops_act.push_back(cur_op);
            chk("rxack_to_req", cyc - rxack_cyc, 1);
            mem_cnt = rand_dly ? $urandom_range(0, 4) : ack_dly;
        end
        prev_req = bus.mem_req;
        bus.mem_rdata = 8'($urandom);
        if (bus.mem_ack) bus.mem_ack = 1'b0;
        else if (bus.mem_req && !mem_hang) begin
            if (mem_cnt > 0) mem_cnt--;
            else begin
                chk("mem_stable", {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00}, cur_op);
                if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = ram[bus.mem_addr];
                bus.mem_ack = 1'b1;
                if (bus.tx_flag) want_txwr = cyc + 1;
            end
        end
    endtask

    // protocol model: what a command does to memory, the bus and the response stream
    task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d);
        rxq.push_back(op);
        if (op == 8'h57) begin
            rxq.push_back(a[15:8]); rxq.push_back(a[7:0]); rxq.push_back(d);
            ops_exp.push_back({1'b1, a[AW-1:0], d});
            ref_mem[a[AW-1:0]] = d;
            resp_exp.push_back(8'h4B);
        end else if (op == 8'h52) begin
            rxq.push_back(a[15:8]); rxq.push_back(a[7:0]);
            ops_exp.push_back({1'b0, a[AW-1:0], 8'h00});
            resp_exp.push_back(ref_mem[a[AW-1:0]]);
        end else resp_exp.push_back(8'h3F);
    endtask

    task automatic settle(input string tag);
        int n = 0;
        while (!(rxq.size() == 0 && resp_act.size() >= resp_exp.size() && tx_busy == 0
                 && !bus.mem_req && bus.tx_flag) && n < 20000) begin
            tick();
            n++;
        end
        chk({tag, "_budget"}, n < 20000, 1);
        repeat (5) tick();
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nops"}, ops_act.size(), ops_exp.size());
        chk({tag, "_nresp"}, resp_act.size(), resp_exp.size());
        for (int i = 0; i < ops_exp.size() && i < ops_act.size(); i++) chk({tag, "_op"}, ops_act[i], ops_exp[i]);
        for (int i = 0; i < resp_exp.size() && i < resp_act.size(); i++) chk({tag, "_resp"}, resp_act[i], resp_exp[i]);
        ops_exp.delete(); ops_act.delete(); resp_exp.delete(); resp_act.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ack"}, bus.rx_ack, 0);
        chk({tag, "_tx_wr"}, bus.tx_wr, 0);
        chk({tag, "_mem_req"}, bus.mem_req, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin
        int base_ack, base_req, base_wr, n;
        logic [7:0] b;
        bus.rx_data = 0; bus.rx_flag = 0; bus.tx_flag = 1; bus.mem_rdata = 0; bus.mem_ack = 0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        repeat (3) tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();
        // write 57 12 34 A5 with a 3-cycle ack delay
        ack_dly = 3;
        base_ack = n_rx_ack;
        send_cmd(8'h57, 16'h1234, 8'hA5);
        settle("write");
        chk("write_rx_acks", n_rx_ack - base_ack, 4);
        compare("write");
        // read 52 00 10 returning 3C
        ram[16'h0010] = 8'h3C; ref_mem[16'h0010] = 8'h3C;
        ack_dly = 1;
        send_cmd(8'h52, 16'h0010, 8'h00);
        settle("read");
        compare("read");
        // unknown opcode, then a normal read
        send_cmd(8'h41, 16'h0, 8'h0);
        send_cmd(8'h52, 16'h0001, 8'h00);
        settle("unknown");
        compare("unknown");
        // timeout after 57 12, then 52 00 02 must parse from IDLE
        base_ack = n_rx_ack; base_req = n_mem_req; base_wr = n_tx_wr;
        rxq.push_back(8'h57); rxq.push_back(8'h12);
        for (n = 0; n < 200 && n_rx_ack - base_ack < 2; n++) tick();
        chk("tmo_bytes_acked", n_rx_ack - base_ack, 2);
        repeat (TMO + 20) tick();
        chk("tmo_no_req", n_mem_req - base_req, 0);
        chk("tmo_no_txwr", n_tx_wr - base_wr, 0);
        send_cmd(8'h52, 16'h0002, 8'h00);
        settle("tmo_after");
        compare("tmo_after");
        // a gap just under the timeout must not abort the command
        base_ack = n_rx_ack;
        rxq.push_back(8'h52);
        for (n = 0; n < 200 && n_rx_ack == base_ack; n++) tick();
        repeat (TMO - 15) tick();
        rxq.push_back(8'h00); rxq.push_back(8'h03);
        ops_exp.push_back({1'b0, 16'h0003, 8'h00});
        resp_exp.push_back(ref_mem[16'h0003]);
        settle("near_tmo");
        compare("near_tmo");
        // back-pressure: transmitter busy for 50 cycles, next command left pending
        tx_hold = 1;
        tick();
        base_ack = n_rx_ack; base_wr = n_tx_wr;
        send_cmd(8'h41, 16'h0, 8'h0);
        send_cmd(8'h57, 16'h0ABC, 8'h99);
        repeat (50) tick();
        chk("bp_no_txwr", n_tx_wr - base_wr, 0);
        chk("bp_tx_data", bus.tx_data, 8'h3F);
        chk("bp_pending_not_acked", n_rx_ack - base_ack, 1);
        chk("bp_rx_pending", bus.rx_flag, 1);
        tx_hold = 0;
        settle("bp");
        chk("bp_txwr_count", n_tx_wr - base_wr, 2);
        compare("bp");
        // random command stream with random ack delays and transmitter busy times
        rand_dly = 1;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            b = 8'($urandom);
            if (b == 8'h57 || b == 8'h52) b = 8'h00;
            send_cmd(n < 5 ? 8'h57 : n < 9 ? 8'h52 : b,
                     {8'($urandom_range(0, 1)), 8'($urandom_range(0, 15))}, 8'($urandom));
        end
        settle("random");
        compare("random");
        // reset while mem_req is held, then a late mem_ack must be ignored
        mem_hang = 1;
        rxq.push_back(8'h52); rxq.push_back(8'h00); rxq.push_back(8'h05);
        for (n = 0; n < 200 && !bus.mem_req; n++) tick();
        chk("rst_req_seen", bus.mem_req, 1);
        base_wr = n_tx_wr;
        reset = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        reset = 1'b0;
        mem_hang = 0;
        bus.mem_ack = 1'b1;
        repeat (20) tick();
        chk("late_ack_no_txwr", n_tx_wr - base_wr, 0);
        chk("late_ack_no_req", bus.mem_req, 0);
        ops_act.delete();
        send_cmd(8'h52, 16'h0010, 8'h00);
        settle("recover");
        compare("recover");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
